// File: rtl/debug_tx_pkg.sv
// Shared types and defaults for the debug serial transmitter.
// Holds the top FSM state type, frame length and parameter defaults.
package debug_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_FINISH
    } tx_state_e;

    localparam int         FRAME_BYTES      = 9;
    localparam int         DEF_CLKS_PER_BIT = 434;
    localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;

    // XOR of the seven snapshot bytes; the sync byte is not included.
    function automatic logic [7:0] snap_csum(input logic [6:0][7:0] b);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < 7; i++) begin
            x = x ^ b[i];
        end
        return x;
    endfunction

endpackage

// File: rtl/debug_serial_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser, LSB first, idle high.
// Ports: clk_i, reset_i (sync, active high), load_i + data_i to start a
// byte, tx_o serial line, ready_o = a load is accepted on this edge.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       ready_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic          active_q, active_d;
    logic [3:0]    bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          bit_end;
    logic          last_cycle;

    // bit_q: 0 = start, 1..8 = data, 9 = stop.
    assign bit_end    = active_q && (cnt_q == CNT_MAX);
    assign last_cycle = bit_end && (bit_q == 4'd9);

    // A load is taken while idle or in the final stop-bit cycle, so the
    // next start bit follows the stop bit with no gap.
    assign ready_o = !active_q || last_cycle;
    assign tx_o    = tx_q;

    always_comb begin
        active_d = active_q;
        bit_d    = bit_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        if (load_i && ready_o) begin
            active_d = 1'b1;
            bit_d    = '0;
            cnt_d    = '0;
            shift_d  = data_i;
            tx_d     = 1'b0;
        end else if (last_cycle) begin
            active_d = 1'b0;
            bit_d    = '0;
            cnt_d    = '0;
            tx_d     = 1'b1;
        end else if (bit_end) begin
            cnt_d = '0;
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'd8) begin
                tx_d = 1'b1;
            end else begin
                tx_d    = shift_q[0];
                shift_d = {1'b0, shift_q[7:1]};
            end
        end else if (active_q) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            active_q <= 1'b0;
            bit_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
        end else begin
            active_q <= active_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/debug_serial_tx.sv
// Snapshots seven CPU debug bytes and sends a 9-byte UART frame:
// SYNC, port1..port7, XOR checksum. Ports: clk_i, reset_i (sync, high),
// start_i, debug_port1_i..7_i, tx_o serial line, busy_o, done_o pulse.
module debug_serial_tx
    import debug_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] debug_port1_i,
    input  logic [7:0] debug_port2_i,
    input  logic [7:0] debug_port3_i,
    input  logic [7:0] debug_port4_i,
    input  logic [7:0] debug_port5_i,
    input  logic [7:0] debug_port6_i,
    input  logic [7:0] debug_port7_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int IW = $clog2(FRAME_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

    tx_state_e       state_q;
    logic [IW-1:0]   idx_q;
    logic            busy_q;
    logic            done_q;
    logic [6:0][7:0] snap_q;
    logic [7:0]      csum_q;

    logic [6:0][7:0] ports;
    logic [IW-1:0]   sel_idx;
    logic [2:0]      snap_k;
    logic [7:0]      byte_sel;
    logic            load;
    logic            byte_ready;

    assign ports = {debug_port7_i, debug_port6_i, debug_port5_i,
                    debug_port4_i, debug_port3_i, debug_port2_i,
                    debug_port1_i};

    // SEND loads the first byte into the idle sender. While waiting,
    // the next byte is presented early so the sender picks it up in
    // the last stop-bit cycle of the current byte.
    assign load = (state_q == ST_SEND) ||
                  ((state_q == ST_WAIT) && (idx_q != LAST_IDX));

    always_comb begin
        sel_idx = (state_q == ST_WAIT) ? idx_q + IW'(1) : idx_q;
        snap_k  = 3'(sel_idx - IW'(1));
        if (sel_idx == '0) begin
            byte_sel = SYNC_BYTE;
        end else if (sel_idx == LAST_IDX) begin
            byte_sel = csum_q;
        end else begin
            byte_sel = snap_q[snap_k];
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .load_i (load),
        .data_i (byte_sel),
        .tx_o   (tx_o),
        .ready_o(byte_ready)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            snap_q  <= '0;
            csum_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        snap_q  <= ports;
                        csum_q  <= snap_csum(ports);
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (byte_ready) begin
                        if (idx_q == LAST_IDX) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FINISH;
                        end else begin
                            idx_q   <= idx_q + IW'(1);
                            state_q <= ST_SEND;
                        end
                    end
                end
                ST_FINISH: begin
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: doc/debug_serial_tx.md
DEBUG_SERIAL_TX -- requirements
Module: debug_serial_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, giving clk cycles per UART bit (50 MHz / 115200).
REQ-002 The block SHALL have parameter SYNC_BYTE, default 8'hA5, giving the frame header byte.
REQ-003 clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to snapshot the debug ports and send one frame; sampled only in IDLE.
REQ-006 debug_port1..debug_port7  input  8 each  CPU debug bytes (pc, cond, decoded fields).
REQ-007 tx  output  1  UART serial line, 8N1, LSB first, idle high.
REQ-008 busy  output  1  high from the cycle after start is accepted until the frame completes.
REQ-009 done  output  1  single-cycle pulse when the last stop bit has ended.

Function
REQ-010 The frame SHALL be 9 bytes in order: SYNC_BYTE, debug_port1..debug_port7, checksum.
REQ-011 Checksum SHALL be the 8-bit XOR of the seven snapshot bytes; SYNC_BYTE is excluded.
REQ-012 When start=1 in IDLE, all seven ports SHALL be registered that edge; later port changes SHALL NOT affect the frame.
REQ-013 The top FSM SHALL have states IDLE, SEND, WAIT, FINISH; IDLE->SEND on accepted start; SEND issues the byte at index 0..8 to the byte sender; SEND->WAIT; WAIT->SEND with index+1 when the sender completes and index<8; WAIT->FINISH when index=8 completes; FINISH->IDLE after one cycle.
REQ-014 Each byte SHALL be a start bit (0), 8 data bits LSB first, and a stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-015 Bytes SHALL be back-to-back: the next start bit SHALL begin on the cycle immediately after the previous stop bit ends, with no idle gap.
REQ-016 tx SHALL fall to 0 on the second edge after the edge that accepts start, i.e. one cycle of latency from the accept edge to the SEND-state output.
REQ-017 A full frame SHALL last 90*CLKS_PER_BIT cycles from the first tx fall to the end of the last stop bit.
REQ-018 done SHALL be high for exactly one cycle (FINISH); busy SHALL be low in that same cycle.
REQ-019 start asserted while busy=1 or in FINISH SHALL be ignored, with no queuing.
REQ-020 start held high continuously SHALL produce consecutive frames separated by exactly one IDLE cycle.
REQ-021 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; its width SHALL be $clog2(CLKS_PER_BIT).
REQ-022 tx SHALL be 1 in every state except during start and data bits.

Reset
REQ-023 On reset=1 at a clock edge, the next-cycle outputs SHALL be tx=1, busy=0, done=0, FSM=IDLE, and counters and index=0.
REQ-024 Reset mid-frame SHALL abort immediately, with no completion of the current byte and no done pulse.
REQ-025 Reset SHALL take priority over start in the same cycle.

Structure
REQ-026 Shared package debug_tx_pkg SHALL hold the FSM state typedef, FRAME_BYTES=9, and the default CLKS_PER_BIT and SYNC_BYTE.
REQ-027 One sub-module, uart_tx_byte (inputs clk, reset, load, data[7:0]; outputs tx, ready), SHALL implement REQ-014; the top instantiates it once.
REQ-028 The block SHALL instantiate in cpu, taking debug_port1..7 directly, with tx routed to the board pin.

Verification (CLKS_PER_BIT=4)
REQ-029 Ports 00,11,22,33,44,55,66 with a one-cycle start -> decoded bytes A5,00,11,22,33,44,55,66,77; done 360 cycles after tx first falls.
REQ-030 Change all ports to FF one cycle after start -> frame is unchanged from REQ-029.
REQ-031 Pulse start again at cycle 100 of a frame -> ignored; exactly one done pulse and one frame.
REQ-032 Assert reset at cycle 150 of a frame -> tx=1 and busy=0 the next cycle; no done pulse; a new start sends a complete, correct frame.
REQ-033 Hold start high for 800 cycles -> two full frames with exactly one idle cycle between done and the next accept.
REQ-034 Check every bit period -> tx is stable for exactly 4 cycles, with no gaps between bytes.
